uart_encoder: RTL and testbench

Transmit-side packer for the board-to-board game link. It snapshots the local game state (role, start flag, keeper position, shot position, score) and serialises it into eight 8-bit frames. Each frame carries a 3-bit opcode in bits [2:0] and 5 payload bits in [7:3]. Frames are written one at a time into the UART TX FIFO, and the frame format matches the link decoder on the opponent board. It sits between the game control logic and the UART transmitter FIFO.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_encoder_gap_timer.sv | 32 +++
 rtl/uart_encoder.sv | 131 +++++++++++++
 tb/tb_uart_encoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the game-link frame format: opcodes, sync marker, FSM states
// and the snapshot record used by the transmit-side packer.
package uart_pkg;

  localparam logic [2:0] OPC_SYNC    = 3'b000;
  localparam logic [2:0] OPC_KEEP_LO = 3'b001;
  localparam logic [2:0] OPC_KEEP_HI = 3'b010;
  localparam logic [2:0] OPC_X_LO    = 3'b011;
  localparam logic [2:0] OPC_X_HI    = 3'b100;
  localparam logic [2:0] OPC_Y_LO    = 3'b101;
  localparam logic [2:0] OPC_Y_HI    = 3'b110;
  localparam logic [2:0] OPC_SCORE   = 3'b111;

  // Bit position of the connection marker inside a full 8-bit sync frame.
  localparam int SYNC_MARKER_BIT = 3;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic       local_shooter;
    logic       game_starts;
    logic [9:0] keeper_pos;
    logic [9:0] x_shooter;
    logic [9:0] y_shooter;
    logic [2:0] player_score;
    logic       is_scored;
    logic       multi_input;
  } snap_t;

endpackage

// File: rtl/uart_encoder_gap_timer.sv
// Inter-round idle countdown: loads GAP_CYCLES on start, decrements each cycle and
// flags expiry while the count sits at zero.
module uart_encoder_gap_timer #(
  parameter int GAP_CYCLES = 65_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expired
);

  localparam int CW = $clog2(GAP_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          running;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= CW'(GAP_CYCLES);
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - CW'(1);
    end
  end

  assign expired = running && (cnt == '0);

endmodule

// File: rtl/uart_encoder.sv
// Game-state packer: snapshots local state and writes eight opcode-tagged frames to the
// UART TX FIFO per round. Optional macro UART_ENCODER_CHANGE_KICK_EN cuts the gap short on input change.
module uart_encoder
  import uart_pkg::*;
#(
  parameter int GAP_CYCLES = 65_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_full,
  input  logic       local_shooter,
  input  logic       game_starts,
  input  logic [9:0] keeper_pos,
  input  logic [9:0] x_shooter,
  input  logic [9:0] y_shooter,
  input  logic [2:0] player_score,
  input  logic       is_scored,
  input  logic       multi_input,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy,
  output logic       round_done
);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       last_q, last_d;
  logic       wr_d, busy_d, done_d;
  logic [7:0] data_d;
  logic [7:0] frame;
  logic       gap_start, gap_expired;
  snap_t      snap_q, live;

  assign live = {local_shooter, game_starts, keeper_pos, x_shooter, y_shooter,
                 player_score, is_scored, multi_input};

  // Snapshot is pure data: it is always reloaded in LOAD before any frame uses it.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD) snap_q <= live;
  end

  always_comb begin
    frame = {5'b00000, idx_q};
    case (idx_q)
      OPC_SYNC: begin
        frame[7:3]             = {snap_q.local_shooter, snap_q.game_starts, 3'b000};
        frame[SYNC_MARKER_BIT] = 1'b1;
      end
      OPC_KEEP_LO: frame[7:3] = snap_q.keeper_pos[4:0];
      OPC_KEEP_HI: frame[7:3] = snap_q.keeper_pos[9:5];
      OPC_X_LO:    frame[7:3] = snap_q.x_shooter[4:0];
      OPC_X_HI:    frame[7:3] = snap_q.x_shooter[9:5];
      OPC_Y_LO:    frame[7:3] = snap_q.y_shooter[4:0];
      OPC_Y_HI:    frame[7:3] = snap_q.y_shooter[9:5];
      OPC_SCORE:   frame[7:3] = {snap_q.multi_input, snap_q.is_scored, snap_q.player_score};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      idx_q      <= 3'd0;
      last_q     <= 1'b0;
      wr_uart    <= 1'b0;
      w_data     <= 8'h00;
      busy       <= 1'b0;
      round_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      wr_uart    <= wr_d;
      w_data     <= data_d;
      busy       <= busy_d;
      round_done <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    wr_d      = 1'b0;
    data_d    = w_data;
    busy_d    = busy;
    done_d    = 1'b0;
    gap_start = 1'b0;
    case (state_q)
      ST_LOAD: begin
        busy_d  = 1'b1;
        idx_d   = 3'd0;
        last_d  = 1'b0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        // A write cycle is always followed by an idle one so tx_full can catch up.
        if (wr_uart) begin
          if (last_q) begin
            state_d   = ST_GAP;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            gap_start = 1'b1;
          end
        end else if (!tx_full) begin
          wr_d   = 1'b1;
          data_d = frame;
          idx_d  = idx_q + 3'd1;
          last_d = (idx_q == OPC_SCORE);
        end
      end
      ST_GAP: begin
        if (gap_expired) state_d = ST_LOAD;
`ifdef UART_ENCODER_CHANGE_KICK_EN
        if (snap_q != live) state_d = ST_LOAD;
`endif
      end
      default: state_d = ST_LOAD;
    endcase
  end

  uart_encoder_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (gap_start),
    .expired(gap_expired)
  );

endmodule

// File: tb/tb_uart_encoder.sv
// Directed bench for uart_encoder: table of input snapshots with hand-computed frames,
// plus sequences for round period, backpressure, snapshot coherence and async reset.
`timescale 1ns/1ps
module tb_uart_encoder;

  localparam int GAP = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_full;
  logic       local_shooter;
  logic       game_starts;
  logic [9:0] keeper_pos;
  logic [9:0] x_shooter;
  logic [9:0] y_shooter;
  logic [2:0] player_score;
  logic       is_scored;
  logic       multi_input;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       busy;
  logic       round_done;

  uart_encoder #(.GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_full      (tx_full),
    .local_shooter(local_shooter),
    .game_starts  (game_starts),
    .keeper_pos   (keeper_pos),
    .x_shooter    (x_shooter),
    .y_shooter    (y_shooter),
    .player_score (player_score),
    .is_scored    (is_scored),
    .multi_input  (multi_input),
    .wr_uart      (wr_uart),
    .w_data       (w_data),
    .busy         (busy),
    .round_done   (round_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  typedef struct {
    logic            ls;
    logic            gs;
    logic [9:0]      kp;
    logic [9:0]      xs;
    logic [9:0]      ys;
    logic [2:0]      sc;
    logic            isc;
    logic            mi;
    logic [0:7][7:0] fr;
  } vec_t;

  vec_t       vecs [4];
  int         checks = 0;
  int         failures = 0;
  int         t0;
  logic [7:0] cap_fr [8];
  int         cap_wc [8];
  int         cap_n;
  int         cap_done;
  int         stall_cyc;
  int         stall_writes;
  int         first_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    local_shooter = v.ls;
    game_starts   = v.gs;
    keeper_pos    = v.kp;
    x_shooter     = v.xs;
    y_shooter     = v.ys;
    player_score  = v.sc;
    is_scored     = v.isc;
    multi_input   = v.mi;
  endtask

  // Holds reset for two cycles, releases it mid-cycle; t0 is the LOAD cycle stamp.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    t0  = cyc;
    @(negedge clk); #1;
    check("cycle1_busy", busy, 1'b1);
    check("cycle1_wr", wr_uart, 1'b0);
  endtask

  // Collects one round of writes. kind 1: stall tx_full 10 cycles after write hook_at;
  // kind 2: change keeper_pos after write hook_at; kind 3: assert rst during write hook_at.
  task automatic capture(input int hook_at, input int kind);
    int stall_left;
    bit seen_done;
    stall_left   = 0;
    seen_done    = 1'b0;
    cap_n        = 0;
    cap_done     = -1;
    stall_writes = 0;
    for (int i = 0; i < 200 && !seen_done; i++) begin
      @(negedge clk); #1;
      if (stall_left > 0) begin
        if (wr_uart) stall_writes++;
        stall_left--;
        if (stall_left == 0) tx_full = 1'b0;
      end
      if (wr_uart) begin
        if (cap_n < 8) begin
          cap_fr[cap_n] = w_data;
          cap_wc[cap_n] = cyc;
        end
        cap_n++;
        if (cap_n == hook_at) begin
          if (kind == 1) begin
            tx_full    = 1'b1;
            stall_left = 10;
            stall_cyc  = cyc;
          end else if (kind == 2) begin
            keeper_pos = 10'h020;
          end else if (kind == 3) begin
            rst = 1'b1;
            #1;
            check("async_rst_wr", wr_uart, 1'b0);
            check("async_rst_data", w_data, 8'h00);
            check("async_rst_busy", busy, 1'b0);
            check("async_rst_done", round_done, 1'b0);
            return;
          end
        end
      end
      if (round_done) begin
        cap_done  = cyc;
        seen_done = 1'b1;
        check("busy_at_done", busy, 1'b0);
      end
    end
    if (!seen_done) begin
      failures++;
      checks++;
      $display("FAIL round_timeout: got %0d writes, no round_done within 200 cycles", cap_n);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 10'h000, 10'h000, 10'h000, 3'd0, 1'b0, 1'b0,
                {8'hC8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}};
    vecs[1] = '{1'b0, 1'b1, 10'h3A5, 10'h155, 10'h2AA, 3'd5, 1'b0, 1'b1,
                {8'h48, 8'h29, 8'hEA, 8'hAB, 8'h54, 8'h55, 8'hAE, 8'hAF}};
    vecs[2] = '{1'b1, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF, 3'd7, 1'b1, 1'b0,
                {8'h88, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'h7F}};
    vecs[3] = '{1'b0, 1'b0, 10'h01F, 10'h020, 10'h000, 3'd0, 1'b1, 1'b1,
                {8'h08, 8'hF9, 8'h02, 8'h03, 8'h0C, 8'h05, 8'h06, 8'hC7}};

    rst     = 1'b0;
    tx_full = 1'b0;
    apply_vec(vecs[0]);
    #2 rst = 1'b1;
    #1;
    check("reset_wr", wr_uart, 1'b0);
    check("reset_data", w_data, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_done", round_done, 1'b0);

    for (int v = 0; v < 4; v++) begin
      apply_vec(vecs[v]);
      do_reset();
      capture(0, 0);
      check($sformatf("v%0d_count", v), cap_n, 8);
      for (int k = 0; k < 8; k++)
        check($sformatf("v%0d_frame%0d", v, k), cap_fr[k], vecs[v].fr[k]);
      check($sformatf("v%0d_first_wr", v), cap_wc[0], t0 + 2);
      for (int k = 1; k < 8; k++)
        check($sformatf("v%0d_spacing%0d", v, k), cap_wc[k] - cap_wc[k-1], 2);
      check($sformatf("v%0d_done_cycle", v), cap_done, t0 + 17);
    end

    // Round period with constant inputs and no backpressure.
    apply_vec(vecs[0]);
    do_reset();
    capture(0, 0);
    first_wr = cap_wc[0];
    capture(0, 0);
    check("period", cap_wc[0] - first_wr, 18 + GAP);
    check("period_frame0", cap_fr[0], 8'hC8);

    // Backpressure after the third write.
    apply_vec(vecs[1]);
    do_reset();
    capture(3, 1);
    check("bp_count", cap_n, 8);
    check("bp_stall_writes", stall_writes, 0);
    check("bp_fourth_wr", cap_wc[3], stall_cyc + 11);
    check("bp_fourth_opc", cap_fr[3][2:0], 3'b011);
    for (int k = 0; k < 8; k++)
      check($sformatf("bp_frame%0d", k), cap_fr[k], vecs[1].fr[k]);
    check("bp_done_cycle", cap_done, cap_wc[7] + 1);
    tx_full = 1'b0;

    // keeper_pos changes between frames 1 and 2; the snapshot must hold.
    apply_vec(vecs[3]);
    do_reset();
    capture(2, 2);
    check("coh_frame1", cap_fr[1], 8'hF9);
    check("coh_frame2", cap_fr[2], 8'h02);
    capture(0, 0);
    check("coh_next_frame1", cap_fr[1], 8'h01);
    check("coh_next_frame2", cap_fr[2], 8'h0A);

    // Async reset during the fourth write, then a clean restart.
    apply_vec(vecs[0]);
    do_reset();
    capture(4, 3);
    do_reset();
    capture(0, 0);
    check("post_rst_opc", cap_fr[0][2:0], 3'b000);
    check("post_rst_frame0", cap_fr[0], 8'hC8);
    check("post_rst_first_wr", cap_wc[0], t0 + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
